hazard_controller: RTL

//  Pipeline sequencing for the 5-stage RV32I core. Sits beside the decode-stage control unit and

---
 rtl/hazard_controller_if.sv | 45 ++++
 rtl/hazard_controller.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hazard_controller_if.sv
// Hazard-control bundle between the decode-side control unit and the pipeline registers.
// The controller uses the slave modport; a driver or testbench uses master.
interface hazard_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  logic [1:0]       ResultSrcE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             PCSrcE;
  logic             MemReqM;
  logic             MemReadyM;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             MemFault;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushEvents;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemFault, StallCycles, FlushEvents
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemFault, StallCycles, FlushEvents
  );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush/forwarding control for the 5-stage RV32I pipeline, with a data-memory wait watchdog.
// Optional saturating perf counters are built only when PERF_COUNTERS_EN is defined.
module hazard_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_controller_if.slave hz
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;

  logic       w_mem_wait;
  logic       w_mem_stall;
  logic       w_lw_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_stall_m;
  logic       w_flush_d;
  logic       w_flush_e;
  logic       w_flush_w;

  // MEM-stage forwarding beats WB since it carries the younger value.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m, input logic [4:0] rd_m,
                                         input logic       wr_w, input logic [4:0] rd_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      fwd_sel = 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) fwd_sel = 2'b01;
    else                                             fwd_sel = 2'b00;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  assign w_mem_wait = hz.MemReqM && !hz.MemReadyM;

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      S_IDLE: begin
        if (w_mem_wait) begin
          w_state_nxt = S_WAIT;
          w_wcnt_nxt  = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        // A withdrawn request ends the wait just like a completion does.
        if (!w_mem_wait) begin
          w_state_nxt = S_IDLE;
          w_wcnt_nxt  = '0;
        end else if (r_wcnt == WCNT_W'(TIMEOUT_CYCLES)) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_wcnt_nxt = r_wcnt + WCNT_W'(1);
        end
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: begin
        w_state_nxt = S_IDLE;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  assign w_mem_stall = ((r_state != S_FAULT) && w_mem_wait) || (r_state == S_FAULT);
  assign w_lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                       ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Memory stall holds EX, so branch and load-use resolution wait until it clears.
  always_comb begin
    w_fwd_a   = 2'b00;
    w_fwd_b   = 2'b00;
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    if (!rst_n) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
      w_flush_w = 1'b1;
    end else begin
      w_fwd_a = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
      w_fwd_b = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
      if (w_mem_stall) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
        w_flush_w = 1'b1;
      end else if (hz.PCSrcE) begin
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
      end else if (w_lw_stall) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
    end
  end

  assign hz.ForwardAE = w_fwd_a;
  assign hz.ForwardBE = w_fwd_b;
  assign hz.StallF    = w_stall_f;
  assign hz.StallD    = w_stall_d;
  assign hz.StallE    = w_stall_e;
  assign hz.StallM    = w_stall_m;
  assign hz.FlushD    = w_flush_d;
  assign hz.FlushE    = w_flush_e;
  assign hz.FlushW    = w_flush_w;
  assign hz.MemFault  = (r_state == S_FAULT);

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_stall_f && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_flush_e && (r_flush_events != '1)) r_flush_events <= r_flush_events + CNT_W'(1);
    end
  end

  assign hz.StallCycles = r_stall_cycles;
  assign hz.FlushEvents = r_flush_events;
`else
  assign hz.StallCycles = '0;
  assign hz.FlushEvents = '0;
`endif

endmodule
